// File: rtl/mem_pkg.sv
// Shared types and helpers for the memory access unit.
package mem_pkg;

  localparam int unsigned DW_W  = 64;
  localparam int unsigned OFF_W = 3;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_RESP = 2'd3
  } state_e;

  // Right-aligned all-ones mask covering one access of the given size.
  function automatic logic [DW_W-1:0] lane_mask(input logic [1:0] sz);
    logic [DW_W-1:0] m;
    case (sz)
      SZ_B:    m = 64'h0000_0000_0000_00FF;
      SZ_H:    m = 64'h0000_0000_0000_FFFF;
      SZ_W:    m = 64'h0000_0000_FFFF_FFFF;
      default: m = 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
    return m;
  endfunction

  // True when the byte offset is not a multiple of the access size.
  function automatic logic misaligned(input logic [OFF_W-1:0] off, input logic [1:0] sz);
    logic r;
    case (sz)
      SZ_B:    r = 1'b0;
      SZ_H:    r = off[0];
      SZ_W:    r = |off[1:0];
      default: r = |off;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/load_extend.sv
// Selects the addressed lane of a doubleword and zero/sign-extends it to 64 bits.
module load_extend
  import mem_pkg::*;
(
  input  logic [DW_W-1:0]  dword,
  input  logic [OFF_W-1:0] off,
  input  logic [1:0]       size,
  input  logic             is_signed,
  output logic [DW_W-1:0]  result
);

  logic [5:0]      shamt;
  logic [DW_W-1:0] lane;
  logic            msb;

  // Shift the lane down, mask it, then extend from its top bit if requested.
  always_comb begin
    shamt  = {off, 3'b000};
    lane   = (dword >> shamt) & lane_mask(size);
    msb    = 1'b0;
    case (size)
      SZ_B:    msb = lane[7];
      SZ_H:    msb = lane[15];
      SZ_W:    msb = lane[31];
      default: msb = 1'b0;
    endcase
    result = lane;
    if (is_signed && (size != SZ_D) && msb) begin
      result = lane | ~lane_mask(size);
    end
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit between the memory pipeline stage and a doubleword data memory.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int size = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [DW_W-1:0]   req_addr,
  input  logic [DW_W-1:0]   req_wdata,
  output logic              rsp_valid,
  output logic [DW_W-1:0]   rsp_data,
  output logic              rsp_err,
  output logic [DW_W-1:0]   mem_address,
  output logic [DW_W-1:0]   mem_wdata,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DW_W-1:0]   mem_rdata
);

  state_e          state_q, state_d;
  logic [DW_W-1:0] addr_q, addr_d;
  logic [1:0]      size_q, size_d;
  logic            signed_q, signed_d;
  logic            write_q, write_d;
  logic [DW_W-1:0] wdata_q, wdata_d;
  logic [DW_W-1:0] rsp_data_q, rsp_data_d;
  logic            rsp_err_q, rsp_err_d;
  logic [DW_W-1:0] mem_wdata_q, mem_wdata_d;

  logic            req_err_c;
  logic [DW_W-1:0] ext_data_c;
  logic [5:0]      shamt_c;
  logic [DW_W-1:0] wmask_c;
  logic [DW_W-1:0] merged_c;

  load_extend u_load_extend (
    .dword     (mem_rdata),
    .off       (addr_q[OFF_W-1:0]),
    .size      (size_q),
    .is_signed (signed_q),
    .result    (ext_data_c)
  );

  // Decode request errors and build the read-modify-write doubleword.
  always_comb begin
    req_err_c = misaligned(req_addr[OFF_W-1:0], req_size) ||
                ({3'b000, req_addr[DW_W-1:OFF_W]} >= 64'(size));
    shamt_c   = {addr_q[OFF_W-1:0], 3'b000};
    wmask_c   = lane_mask(size_q) << shamt_c;
    merged_c  = (mem_rdata & ~wmask_c) | ((wdata_q << shamt_c) & wmask_c);
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    size_d      = size_q;
    signed_d    = signed_q;
    write_d     = write_q;
    wdata_d     = wdata_q;
    rsp_data_d  = '0;
    rsp_err_d   = 1'b0;
    mem_wdata_d = '0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          addr_d   = req_addr;
          size_d   = req_size;
          signed_d = req_signed;
          write_d  = req_write;
          wdata_d  = req_wdata;
          if (req_err_c) begin
            state_d   = ST_RESP;
            rsp_err_d = 1'b1;
          end else if (!req_write) begin
            state_d = ST_RD;
          end else if (req_size == SZ_D) begin
            state_d     = ST_WR;
            mem_wdata_d = req_wdata;
          end else begin
            state_d = ST_RD;
          end
        end
      end
      ST_RD: begin
        if (write_q) begin
          state_d     = ST_WR;
          mem_wdata_d = merged_c;
        end else begin
          state_d    = ST_RESP;
          rsp_data_d = ext_data_c;
        end
      end
      ST_WR:   state_d = ST_RESP;
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      size_q      <= '0;
      signed_q    <= 1'b0;
      write_q     <= 1'b0;
      wdata_q     <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      size_q      <= size_d;
      signed_q    <= signed_d;
      write_q     <= write_d;
      wdata_q     <= wdata_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign req_ready   = (state_q == ST_IDLE);
  assign mem_read    = (state_q == ST_RD);
  assign mem_write   = (state_q == ST_WR);
  assign rsp_valid   = (state_q == ST_RESP);
  assign rsp_data    = rsp_data_q;
  assign rsp_err     = rsp_err_q;
  assign mem_wdata   = mem_wdata_q;
  assign mem_address = {3'b000, addr_q[DW_W-1:OFF_W]};

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit with a byte-level memory model.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_write, req_signed;
  logic [1:0]  req_size;
  logic [63:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_err;
  logic [63:0] rsp_data, mem_address, mem_wdata, mem_rdata;
  logic        mem_read, mem_write;

  always #5 clk = ~clk;

  mem_access_unit #(.size(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .mem_address(mem_address), .mem_wdata(mem_wdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_rdata(mem_rdata)
  );

  // Attached data memory: combinational read, write on rising edge.
  logic [63:0] mem [32];
  logic        init_done = 1'b0;
  assign mem_rdata = (mem_address < 64'd32) ? mem[mem_address[4:0]] : 64'd0;
  always @(posedge clk) begin
    if (!init_done) begin
      for (int j = 0; j < 32; j++) mem[j] <= 64'(j);
    end else if (mem_write && (mem_address < 64'd32)) begin
      mem[mem_address[4:0]] <= mem_wdata;
    end
  end

  // Reference model state and expectations for the request in flight.
  logic [63:0] ref_mem [32];
  int          n_checks = 0;
  int          n_fail = 0;
  bit          mon_en = 1'b0;
  bit          active = 1'b0;
  int          cyc = 0;
  int          exp_lat = 0;
  bit [7:0]    exp_rd, exp_wr;
  logic [63:0] exp_data, exp_wdata, exp_idx;
  bit          exp_err;
  logic [63:0] last_data;
  logic        last_err;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h expected 0x%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] model_load(input logic [63:0] dw, input int off,
                                             input int nb, input bit sgn);
    logic [63:0] v = 64'd0;
    for (int b = 0; b < nb; b++) v[8*b +: 8] = dw[8*(off+b) +: 8];
    if (sgn && nb < 8 && v[8*nb-1]) begin
      for (int b = nb; b < 8; b++) v[8*b +: 8] = 8'hFF;
    end
    return v;
  endfunction

  function automatic logic [63:0] model_store(input logic [63:0] old, input logic [63:0] wd,
                                              input int off, input int nb);
    logic [63:0] v = old;
    for (int b = 0; b < nb; b++) v[8*(off+b) +: 8] = wd[8*b +: 8];
    return v;
  endfunction

  // Per-cycle compare of every output against the expectation in flight.
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (active) cyc++;
        chk("rd_wr_exclusive", 64'(mem_read & mem_write), 64'd0);
        if (!rsp_valid) chk("rsp_data_idle", rsp_data, 64'd0);
        if (!mem_write) chk("mem_wdata_idle", mem_wdata, 64'd0);
        chk("req_ready", 64'(req_ready), 64'(!active));
        if (active) begin
          chk("mem_read", 64'(mem_read), 64'((cyc < 8) ? exp_rd[cyc] : 1'b0));
          chk("mem_write", 64'(mem_write), 64'((cyc < 8) ? exp_wr[cyc] : 1'b0));
          chk("rsp_valid", 64'(rsp_valid), 64'(cyc == exp_lat));
          if (mem_read || mem_write) chk("mem_address", mem_address, exp_idx);
          if (mem_write) chk("mem_wdata", mem_wdata, exp_wdata);
          if (cyc == exp_lat) begin
            chk("rsp_data", rsp_data, exp_data);
            chk("rsp_err", 64'(rsp_err), 64'(exp_err));
            last_data = rsp_data;
            last_err  = rsp_err;
            active    = 1'b0;
          end
        end else begin
          chk("mem_read_quiet", 64'(mem_read), 64'd0);
          chk("mem_write_quiet", 64'(mem_write), 64'd0);
          chk("rsp_valid_quiet", 64'(rsp_valid), 64'd0);
        end
      end
    end
  end

  // Wait for an idle unit and present a request; true when it is driven.
  task automatic present(input bit wr, input logic [1:0] sz, input bit sgn,
                         input logic [63:0] addr, input logic [63:0] wd, output bit ok);
    int guard = 0;
    @(negedge clk);
    while (!req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    ok = req_ready;
    if (!ok) begin
      chk("ready_timeout", 64'd0, 64'd1);
      return;
    end
    req_valid  = 1'b1;
    req_write  = wr;
    req_size   = sz;
    req_signed = sgn;
    req_addr   = addr;
    req_wdata  = wd;
  endtask

  task automatic do_req(input bit wr, input logic [1:0] sz, input bit sgn,
                        input logic [63:0] addr, input logic [63:0] wd);
    bit          ok;
    int          nb, off, guard;
    logic [63:0] idx, old;
    bit          err;
    present(wr, sz, sgn, addr, wd, ok);
    if (!ok) return;
    nb  = 1 << sz;
    off = int'(addr[2:0]);
    idx = addr >> 3;
    err = ((off % nb) != 0) || (idx >= 64'd32);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    exp_rd = '0; exp_wr = '0; exp_data = '0; exp_wdata = '0; exp_err = err; exp_idx = idx;
    if (err) begin
      exp_lat = 1;
    end else begin
      old = ref_mem[idx[4:0]];
      if (!wr) begin
        exp_lat   = 2;
        exp_rd[1] = 1'b1;
        exp_data  = model_load(old, off, nb, sgn);
      end else begin
        exp_wdata = model_store(old, wd, off, nb);
        ref_mem[idx[4:0]] = exp_wdata;
        if (nb == 8) begin
          exp_lat   = 2;
          exp_wr[1] = 1'b1;
        end else begin
          exp_lat   = 3;
          exp_rd[1] = 1'b1;
          exp_wr[2] = 1'b1;
        end
      end
    end
    cyc    = 0;
    active = 1'b1;
    guard  = 0;
    while (active && guard < 10) begin
      @(posedge clk);
      guard++;
    end
    if (active) begin
      chk("rsp_timeout", 64'd0, 64'd1);
      active = 1'b0;
    end
  endtask

  // Partial store aborted by reset during its read cycle.
  task automatic reset_mid_rmw();
    bit ok;
    present(1'b1, 2'd0, 1'b0, 64'h1B, 64'hAA, ok);
    if (!ok) return;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    exp_rd = 8'b0000_0010; exp_wr = '0; exp_lat = 99; exp_idx = 64'd3;
    exp_data = '0; exp_wdata = '0; exp_err = 1'b0;
    cyc    = 0;
    active = 1'b1;
    rst    = 1'b1;
    @(posedge clk);
    #1;
    active = 1'b0;
    rst    = 1'b0;
    @(negedge clk);
    chk("abort_ready", 64'(req_ready), 64'd1);
    chk("abort_no_rsp", 64'(rsp_valid), 64'd0);
    chk("abort_no_write", 64'(mem_write), 64'd0);
    repeat (3) @(negedge clk);
    chk("abort_entry3", mem[3], 64'd3);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  sz;
    logic [63:0] idx, off, addr;
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0;
    req_signed = 1'b0; req_addr = '0; req_wdata = '0;
    for (int j = 0; j < 32; j++) ref_mem[j] = 64'(j);
    repeat (3) @(posedge clk);
    #1 init_done = 1'b1;
    @(negedge clk);
    chk("reset_ready", 64'(req_ready), 64'd1);
    chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("reset_rsp_err", 64'(rsp_err), 64'd0);
    chk("reset_rsp_data", rsp_data, 64'd0);
    chk("reset_mem_read", 64'(mem_read), 64'd0);
    chk("reset_mem_write", 64'(mem_write), 64'd0);
    chk("reset_mem_address", mem_address, 64'd0);
    chk("reset_mem_wdata", mem_wdata, 64'd0);
    rst    = 1'b0;
    mon_en = 1'b1;

    do_req(1'b0, 2'd3, 1'b0, 64'h28, 64'd0);
    chk("lit_load_0x28", last_data, 64'd5);
    do_req(1'b1, 2'd0, 1'b0, 64'h09, 64'hFF);
    do_req(1'b0, 2'd3, 1'b0, 64'h08, 64'd0);
    chk("lit_load_0x08", last_data, 64'h0000_0000_0000_FF01);
    do_req(1'b0, 2'd0, 1'b1, 64'h09, 64'd0);
    chk("lit_sbyte_0x09", last_data, 64'hFFFF_FFFF_FFFF_FFFF);
    do_req(1'b0, 2'd0, 1'b0, 64'h09, 64'd0);
    chk("lit_ubyte_0x09", last_data, 64'h0000_0000_0000_00FF);
    do_req(1'b0, 2'd2, 1'b0, 64'h0A, 64'd0);
    chk("lit_err_misalign", 64'(last_err), 64'd1);
    do_req(1'b0, 2'd3, 1'b0, 64'h100, 64'd0);
    chk("lit_err_range", 64'(last_err), 64'd1);
    do_req(1'b1, 2'd1, 1'b0, 64'h16, 64'hBEEF);
    chk("lit_entry2", mem[2], 64'hBEEF_0000_0000_0002);
    reset_mid_rmw();

    for (int n = 0; n < 300; n++) begin
      sz  = 2'($urandom_range(0, 3));
      idx = ($urandom_range(0, 9) == 0) ? 64'($urandom_range(32, 40)) : 64'($urandom_range(0, 31));
      if ($urandom_range(0, 3) == 0) off = 64'($urandom_range(0, 7));
      else off = 64'(($urandom_range(0, 7) >> sz) << sz);
      addr = (idx << 3) | off;
      if ($urandom_range(0, 19) == 0) addr[63] = 1'b1;
      do_req(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), addr,
             {32'($urandom), 32'($urandom)});
      if ($urandom_range(0, 2) == 0) @(negedge clk);
    end

    repeat (2) @(negedge clk);
    for (int j = 0; j < 32; j++) chk("final_mem", mem[j], ref_mem[j]);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 The module SHALL have parameter size, default 32, meaning the number of 64-bit doubleword entries in the attached data memory.
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-003 The module SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The module SHALL have port req_valid, input, 1 bit: the upstream memory-stage request is present.
REQ-005 The module SHALL have port req_ready, output, 1 bit: the unit can accept a request.
REQ-006 The module SHALL have port req_write, input, 1 bit: 1 = store, 0 = load.
REQ-007 The module SHALL have port req_size, input, 2 bits: access size; 0 = byte, 1 = half, 2 = word, 3 = doubleword.
REQ-008 The module SHALL have port req_signed, input, 1 bit: sign-extend load data (LDURSW-style); ignored for stores.
REQ-009 The module SHALL have port req_addr, input, 64 bits: byte address.
REQ-010 The module SHALL have port req_wdata, input, 64 bits: store data, right-aligned.
REQ-011 The module SHALL have port rsp_valid, output, 1 bit: a one-cycle completion pulse.
REQ-012 The module SHALL have port rsp_data, output, 64 bits: load result, zero for stores and errors.
REQ-013 The module SHALL have port rsp_err, output, 1 bit: the request was misaligned or out of range.
REQ-014 The module SHALL have port mem_address, output, 64 bits: doubleword index driven to the data memory.
REQ-015 The module SHALL have port mem_wdata, output, 64 bits: write data driven to the data memory.
REQ-016 The module SHALL have port mem_read, output, 1 bit: read enable to the data memory.
REQ-017 The module SHALL have port mem_write, output, 1 bit: write enable to the data memory, sampled by the memory at the clk rising edge.
REQ-018 The module SHALL have port mem_rdata, input, 64 bits: combinational read data returned by the data memory.

Function
REQ-019 The unit SHALL implement FSM states IDLE, RD, WR and RESP.
REQ-020 req_ready SHALL equal (state==IDLE); a request is accepted at a rising edge where req_valid && req_ready, and all req_* fields are registered at acceptance.
REQ-021 mem_address SHALL equal the registered addr[63:3], and the byte offset off SHALL equal addr[2:0].
REQ-022 A request SHALL be an error if off is not a multiple of 2^req_size or if addr[63:3] >= size; on error the FSM goes IDLE->RESP, mem_read and mem_write are never asserted, and rsp_err=1.
REQ-023 For a valid load, the FSM SHALL go IDLE->RD->RESP; in RD, mem_read=1 and the result is captured at the end of RD.
REQ-024 Load extraction SHALL select the lane mem_rdata[8*off +: 8<<req_size], then zero-extend it, or sign-extend it when req_signed=1; doubleword loads pass through unchanged.
REQ-025 For a doubleword store, the FSM SHALL go IDLE->WR->RESP; in WR, mem_write=1 and mem_wdata=req_wdata.
REQ-026 For a sub-doubleword store, the FSM SHALL go IDLE->RD->WR->RESP, performing a read-modify-write.
REQ-027 In the read-modify-write of REQ-026, RD SHALL capture the old doubleword and WR SHALL write it with only the addressed lane replaced by the low bytes of req_wdata.
REQ-028 In RESP, rsp_valid SHALL be 1 for exactly one cycle, after which the FSM returns to IDLE; no new request is accepted in RESP.
REQ-029 Latency from the acceptance edge to rsp_valid SHALL be: error 1 cycle; load or doubleword store 2 cycles; partial store 3 cycles.
REQ-030 mem_read and mem_write SHALL never be asserted together.
REQ-031 Outside RD and WR, mem_read and mem_write SHALL be 0, and mem_wdata SHALL be 0 outside WR.
REQ-032 req_valid asserted while req_ready=0 SHALL be ignored; upstream holds the request until it is accepted.
REQ-033 rsp_data SHALL be 0 whenever rsp_valid=0.

Reset
REQ-034 When rst=1 at a rising edge, state SHALL become IDLE and all registers SHALL clear.
REQ-035 After reset, outputs SHALL be: req_ready=1; rsp_valid=0; rsp_err=0; rsp_data=0; mem_read=0; mem_write=0; mem_address=0; mem_wdata=0.
REQ-036 On reset in mid-operation, no response SHALL be produced for the aborted request.
REQ-037 On reset in mid-operation, a WR-cycle write coinciding with the reset edge SHALL still be sampled by the memory, and no write SHALL occur after the reset edge.
REQ-038 rst SHALL take priority over request acceptance at the same edge.

Structure
REQ-039 Package mem_pkg SHALL hold the FSM state enum, the access-size encodings (SZ_B, SZ_H, SZ_W, SZ_D) and the doubleword byte-offset width constant.
REQ-040 A combinational sub-module load_extend (inputs: doubleword, off, size, signed; output: 64-bit result) SHALL perform lane select and extension, and the same lane logic SHALL drive store merge masks.

Verification
REQ-041 The bench SHALL preload memory entry j=j and, with req_size=3, load addr 0x28, expecting rsp_data=5, rsp_valid 2 cycles after acceptance, and mem_read high 1 cycle.
REQ-042 The bench SHALL store byte 0xFF at addr 0x09, then doubleword-load addr 0x08, expecting 0x000000000000FF01.
REQ-043 The bench SHALL then perform a signed-byte load from addr 0x09, expecting 0xFFFFFFFFFFFFFFFF, and an unsigned load from the same address, expecting 0x00000000000000FF.
REQ-044 The bench SHALL load a word from addr 0x0A, expecting rsp_err=1 after 1 cycle with no mem_read/mem_write, and a doubleword from addr 0x100 (index 32 with size=32), expecting rsp_err=1.
REQ-045 The bench SHALL store a half-word 0xBEEF at addr 0x16, expecting the RD->WR sequence and entry 2 = 0xBEEF000000000002.
REQ-046 The bench SHALL assert rst during the RD cycle of a partial store, expecting no write, no rsp_valid, req_ready=1 the next cycle, and entry contents unchanged.
